// File: rtl/elevator_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// elevator_dispatch_ctrl
//   SCAN (collective) scheduler for a 4-floor car. It latches car and hall
//   calls into a sticky request vector and tracks the car position from a
//   floor-arrival strobe. It sequences the motor up/down, stops at requested
//   floors, and runs a timed door-open phase that an obstruction or a press at
//   the current floor retriggers.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-high reset
//   car_btn[3:0]   in   in-car floor buttons, level, bit n = floor n
//   hall_up[3:0]   in   hall up calls (bit 3 ignored)
//   hall_dn[3:0]   in   hall down calls (bit 0 ignored)
//   floor_arrive   in   one-cycle strobe, next floor in travel direction reached
//   door_obstruct  in   door beam broken, level
//   cur_floor[1:0] out  current car floor
//   motor_up       out  drive car upward
//   motor_dn       out  drive car downward
//   door_open      out  door open command
//   pending[3:0]   out  latched, not-yet-served requests
//   dir_up         out  SCAN direction preference (1 = up)
//   state[1:0]     out  0 IDLE, 1 UP, 2 DOWN, 3 DOOR
// ---------------------------------------------------------------------------
module elevator_dispatch_ctrl #(
    parameter int NUM_FLOORS  = 4,
    parameter int FLOOR_W     = 2,
    parameter int DOOR_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] car_btn,
    input  logic [NUM_FLOORS-1:0] hall_up,
    input  logic [NUM_FLOORS-1:0] hall_dn,
    input  logic                  floor_arrive,
    input  logic                  door_obstruct,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  motor_up,
    output logic                  motor_dn,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DOOR = 2'd3
    } state_e;

    localparam logic [FLOOR_W-1:0]    TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0]    BOT_FLOOR = {FLOOR_W{1'b0}};
    localparam logic [FLOOR_W-1:0]    FLOOR_ONE = FLOOR_W'(1);
    localparam logic [CNT_W-1:0]      DOOR_LOAD = CNT_W'(DOOR_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
    // Top floor has no up call, bottom floor has no down call.
    localparam logic [NUM_FLOORS-1:0] UP_MASK   = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DN_MASK   = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

    state_e                  state_r, state_nxt_s;
    logic [FLOOR_W-1:0]      cur_floor_r, floor_nxt_s;
    logic                    dir_up_r, dir_nxt_s;
    logic [CNT_W-1:0]        door_cnt_r, cnt_nxt_s;
    logic [NUM_FLOORS-1:0]   pending_r, clear_mask_s;
    logic [NUM_FLOORS-1:0]   req_now_s, req_all_s;
    logic                    motor_up_r, motor_dn_r, door_open_r;
    logic                    above_s, below_s, here_s;
    logic [FLOOR_W-1:0]      up_floor_s, dn_floor_s;

    // One-hot mask selecting a single floor.
    function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] idx);
        floor_bit = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign req_now_s  = car_btn | (hall_up & UP_MASK) | (hall_dn & DN_MASK);
    assign req_all_s  = pending_r | req_now_s;
    assign here_s     = req_all_s[cur_floor_r];
    // Position updates saturate at the shaft ends.
    assign up_floor_s = (cur_floor_r == TOP_FLOOR) ? cur_floor_r : cur_floor_r + FLOOR_ONE;
    assign dn_floor_s = (cur_floor_r == BOT_FLOOR) ? cur_floor_r : cur_floor_r - FLOOR_ONE;

    // Are there latched requests strictly above / below the car?
    always_comb begin
        above_s = 1'b0;
        below_s = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_r[i] && (i > int'(cur_floor_r))) begin
                above_s = 1'b1;
            end else if (pending_r[i] && (i < int'(cur_floor_r))) begin
                below_s = 1'b1;
            end else begin
                above_s = above_s;
            end
        end
    end

    // Next-state, position, direction, door counter and request-clear logic.
    always_comb begin
        state_nxt_s  = state_r;
        floor_nxt_s  = cur_floor_r;
        dir_nxt_s    = dir_up_r;
        cnt_nxt_s    = door_cnt_r;
        clear_mask_s = {NUM_FLOORS{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (here_s) begin
                    state_nxt_s  = ST_DOOR;
                    cnt_nxt_s    = DOOR_LOAD;
                    clear_mask_s = floor_bit(cur_floor_r);
                end else if (above_s && (dir_up_r || !below_s)) begin
                    state_nxt_s = ST_UP;
                    dir_nxt_s   = 1'b1;
                end else if (below_s) begin
                    state_nxt_s = ST_DOWN;
                    dir_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_UP: begin
                if (floor_arrive) begin
                    floor_nxt_s = up_floor_s;
                    // Stop on a request at the new floor (including one
                    // pressed on the arrival cycle) or at the top.
                    if (req_all_s[up_floor_s] || (up_floor_s == TOP_FLOOR)) begin
                        state_nxt_s  = ST_DOOR;
                        cnt_nxt_s    = DOOR_LOAD;
                        clear_mask_s = floor_bit(up_floor_s);
                    end else begin
                        state_nxt_s = ST_UP;
                    end
                end else begin
                    state_nxt_s = ST_UP;
                end
            end
            ST_DOWN: begin
                if (floor_arrive) begin
                    floor_nxt_s = dn_floor_s;
                    if (req_all_s[dn_floor_s] || (dn_floor_s == BOT_FLOOR)) begin
                        state_nxt_s  = ST_DOOR;
                        cnt_nxt_s    = DOOR_LOAD;
                        clear_mask_s = floor_bit(dn_floor_s);
                    end else begin
                        state_nxt_s = ST_DOWN;
                    end
                end else begin
                    state_nxt_s = ST_DOWN;
                end
            end
            ST_DOOR: begin
                // Presses at the open floor are served immediately.
                clear_mask_s = floor_bit(cur_floor_r);
                if (door_obstruct || req_now_s[cur_floor_r]) begin
                    cnt_nxt_s = DOOR_LOAD;
                end else if (door_cnt_r <= CNT_ONE) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = door_cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, position, request and output registers; outputs are decoded
    // from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cur_floor_r <= BOT_FLOOR;
            dir_up_r    <= 1'b1;
            door_cnt_r  <= CNT_ZERO;
            pending_r   <= {NUM_FLOORS{1'b0}};
            motor_up_r  <= 1'b0;
            motor_dn_r  <= 1'b0;
            door_open_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cur_floor_r <= floor_nxt_s;
            dir_up_r    <= dir_nxt_s;
            door_cnt_r  <= cnt_nxt_s;
            pending_r   <= (pending_r | req_now_s) & ~clear_mask_s;
            motor_up_r  <= (state_nxt_s == ST_UP);
            motor_dn_r  <= (state_nxt_s == ST_DOWN);
            door_open_r <= (state_nxt_s == ST_DOOR);
        end
    end

    assign cur_floor = cur_floor_r;
    assign motor_up  = motor_up_r;
    assign motor_dn  = motor_dn_r;
    assign door_open = door_open_r;
    assign pending   = pending_r;
    assign dir_up    = dir_up_r;
    assign state     = state_r;

endmodule
